// File: rtl/fpu_pkg.sv
// Shared encodings, constants and operand helpers for the binary32 add/sub/mul pipeline.
// FPU_DENORM_EN selects exact subnormal handling; otherwise subnormals flush to zero.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2
  } fpu_op_e;

  typedef enum logic [1:0] {
    RM_RZ  = 2'd0,
    RM_RD  = 2'd1,
    RM_RNE = 2'd2,
    RM_RU  = 2'd3
  } rmode_e;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] MAX_FIN = 32'h7F7FFFFF;
  localparam int unsigned BIAS    = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
  } fp_unp_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
  } fp_opnd_t;

  // Precomputed result for NaN/infinity/unsupported cases, bypassing the datapath.
  typedef struct packed {
    logic        hit;
    logic [31:0] res;
    logic        snan;
    logic        qnan;
  } fp_spec_t;

  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t    u;
    logic [7:0] e;
    logic [22:0] f;
    e         = x[30:23];
    f         = x[22:0];
    u.sign    = x[31];
    u.is_inf  = (e == 8'hFF) && (f == 23'd0);
    u.is_nan  = (e == 8'hFF) && (f != 23'd0);
    u.is_snan = u.is_nan && !f[22];
    if (e == 8'd0) begin
`ifdef FPU_DENORM_EN
      u.is_zero = (f == 23'd0);
      u.exp     = (f == 23'd0) ? 8'd0 : 8'd1;
      u.man     = {1'b0, f};
`else
      u.is_zero = 1'b1;
      u.exp     = 8'd0;
      u.man     = 24'd0;
`endif
    end else begin
      u.is_zero = 1'b0;
      u.exp     = e;
      u.man     = {1'b1, f};
    end
    return u;
  endfunction

  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int unsigned i = 0; i < 48; i++) begin
      if (v[i]) n = 6'(47 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_round.sv
// Round/pack: applies rmode to a normalized significand + GRS and handles overflow/underflow.
// FPU_DENORM_EN: exponent 0 marks a denormalized input; otherwise tiny results flush to zero.
module fpu_round
  import fpu_pkg::*;
(
  input  logic               sign,
  input  logic signed [11:0] exp,
  input  logic [23:0]        sig,
  input  logic               g,
  input  logic               r,
  input  logic               s,
  input  rmode_e             rmode,
  output logic [31:0]        res,
  output logic               ine,
  output logic               overflow,
  output logic               underflow
);

  logic        inexact;
  logic        inc;
  logic        to_inf;
  logic        ovf;
  logic [30:0] rnd;

  always_comb begin
    inexact = g | r | s;
    case (rmode)
      RM_RNE:  inc = g & (r | s | sig[0]);
      RM_RD:   inc = sign & inexact;
      RM_RU:   inc = ~sign & inexact;
      default: inc = 1'b0;
    endcase
    // Adding into {exp,frac} lets a mantissa carry bump the exponent (incl. denormal -> normal).
    rnd    = {exp[7:0], sig[22:0]} + {30'd0, inc};
    to_inf = (rmode == RM_RNE) | ((rmode == RM_RD) & sign) | ((rmode == RM_RU) & ~sign);
    ovf    = (exp > 12'sd254) | ((exp >= 12'sd0) & (rnd[30:23] == 8'hFF));

    res       = {sign, rnd};
    ine       = inexact;
    overflow  = 1'b0;
    underflow = 1'b0;
    if ((sig == 24'd0) && !inexact) begin
      res = {sign, 31'd0};
      ine = 1'b0;
    end else if (ovf) begin
      overflow = 1'b1;
      ine      = 1'b1;
      res      = to_inf ? {sign, 8'hFF, 23'd0} : {sign, MAX_FIN[30:0]};
    end
`ifdef FPU_DENORM_EN
    else begin
      underflow = (exp == 12'sd0) & inexact;
    end
`else
    else if ((exp < 12'sd0) || (rnd[30:23] == 8'd0)) begin
      res       = {sign, 31'd0};
      ine       = 1'b1;
      underflow = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fpu_core.sv
// Pipelined binary32 add/sub/mul: input capture, unpack, align/multiply, normalize, round.
// Define FPU_DENORM_EN for exact subnormals; default build flushes subnormals to zero.
module fpu_core
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [31:0] out,
  output logic        snan,
  output logic        qnan,
  output logic        inf,
  output logic        ine,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        zero
);

  // Input capture so that operands sampled on edge N yield results after edge N+4.
  logic        in_v_d, in_v_q;
  logic [2:0]  in_op_d, in_op_q;
  rmode_e      in_rm_d, in_rm_q;
  logic [31:0] in_a_d, in_a_q, in_b_d, in_b_q;

  logic        s1_v_d, s1_v_q, s1_mul_d, s1_mul_q;
  rmode_e      s1_rm_d, s1_rm_q;
  fp_opnd_t    s1_a_d, s1_a_q, s1_b_d, s1_b_q;
  fp_spec_t    s1_sp_d, s1_sp_q;
  fp_unp_t     ua, ub;

  logic               s2_v_d, s2_v_q, s2_sign_d, s2_sign_q;
  logic signed [11:0] s2_exp_d, s2_exp_q;
  logic [47:0]        s2_mant_d, s2_mant_q;
  rmode_e             s2_rm_d, s2_rm_q;
  fp_spec_t           s2_sp_d, s2_sp_q;
  fp_opnd_t           big, sml;
  logic [7:0]         ediff;
  logic [4:0]         sh;
  logic [55:0]        wide;
  logic [26:0]        big_al, sml_al;
  logic [27:0]        sum;

  logic               s3_v_d, s3_v_q, s3_sign_d, s3_sign_q;
  logic signed [11:0] s3_exp_d, s3_exp_q;
  logic [23:0]        s3_sig_d, s3_sig_q;
  logic               s3_g_d, s3_g_q, s3_r_d, s3_r_q, s3_s_d, s3_s_q;
  rmode_e             s3_rm_d, s3_rm_q;
  fp_spec_t           s3_sp_d, s3_sp_q;
  logic [5:0]         lz;
  logic [47:0]        norm;
  logic signed [11:0] e_n;
  logic               xs;
`ifdef FPU_DENORM_EN
  logic signed [11:0] dsh;
  logic [6:0]         dsh_amt;
  logic [95:0]        ext;
`endif

  logic [31:0] rnd_res;
  logic        rnd_ine, rnd_ovf, rnd_unf;
  logic [31:0] out_d, out_q;
  logic        snan_d, snan_q, qnan_d, qnan_q, inf_d, inf_q, ine_d, ine_q;
  logic        ovf_d, ovf_q, unf_d, unf_q, zero_d, zero_q;

  always_comb begin
    in_v_d  = 1'b1;
    in_op_d = fpu_op;
    in_rm_d = rmode_e'(rmode);
    in_a_d  = opa;
    in_b_d  = opb;
  end

  // Stage 1: unpack and special-case detection
  always_comb begin
    ua = fp_unpack(in_a_q);
    ub = fp_unpack(in_b_q);
    if (in_op_q == OP_SUB) ub.sign = ~ub.sign;
    s1_v_d   = in_v_q;
    s1_rm_d  = in_rm_q;
    s1_mul_d = (in_op_q == OP_MUL);
    s1_a_d   = '{sign: ua.sign, exp: ua.exp, man: ua.man};
    s1_b_d   = '{sign: ub.sign, exp: ub.exp, man: ub.man};
    s1_sp_d     = '0;
    s1_sp_d.res = QNAN;
    if (in_op_q > OP_MUL) begin
      s1_sp_d.hit  = 1'b1;
      s1_sp_d.qnan = 1'b1;
    end else if (ua.is_nan | ub.is_nan) begin
      s1_sp_d.hit  = 1'b1;
      s1_sp_d.qnan = 1'b1;
      s1_sp_d.snan = ua.is_snan | ub.is_snan;
    end else if (s1_mul_d) begin
      if ((ua.is_inf & ub.is_zero) | (ua.is_zero & ub.is_inf)) begin
        s1_sp_d.hit  = 1'b1;
        s1_sp_d.qnan = 1'b1;
      end else if (ua.is_inf | ub.is_inf) begin
        s1_sp_d.hit = 1'b1;
        s1_sp_d.res = {ua.sign ^ ub.sign, 8'hFF, 23'd0};
      end
    end else begin
      if (ua.is_inf & ub.is_inf & (ua.sign != ub.sign)) begin
        s1_sp_d.hit  = 1'b1;
        s1_sp_d.qnan = 1'b1;
      end else if (ua.is_inf) begin
        s1_sp_d.hit = 1'b1;
        s1_sp_d.res = {ua.sign, 8'hFF, 23'd0};
      end else if (ub.is_inf) begin
        s1_sp_d.hit = 1'b1;
        s1_sp_d.res = {ub.sign, 8'hFF, 23'd0};
      end
    end
  end

  // Stage 2: align+add or multiply; both leave the binary point at mant bit 46
  always_comb begin
    s2_v_d  = s1_v_q;
    s2_rm_d = s1_rm_q;
    s2_sp_d = s1_sp_q;
    big     = s1_a_q;
    sml     = s1_b_q;
    ediff   = '0;
    sh      = '0;
    wide    = '0;
    big_al  = '0;
    sml_al  = '0;
    sum     = '0;
    if (s1_mul_q) begin
      s2_mant_d = 48'(s1_a_q.man) * 48'(s1_b_q.man);
      s2_exp_d  = $signed({4'd0, s1_a_q.exp}) + $signed({4'd0, s1_b_q.exp}) - 12'(BIAS);
      s2_sign_d = s1_a_q.sign ^ s1_b_q.sign;
    end else begin
      if ({s1_b_q.exp, s1_b_q.man} > {s1_a_q.exp, s1_a_q.man}) begin
        big = s1_b_q;
        sml = s1_a_q;
      end
      ediff  = big.exp - sml.exp;
      sh     = (ediff > 8'd31) ? 5'd31 : ediff[4:0];
      wide   = {sml.man, 32'd0} >> sh;
      sml_al = {wide[55:30], |wide[29:0]};
      big_al = {big.man, 3'd0};
      sum    = (big.sign == sml.sign) ? ({1'b0, big_al} + {1'b0, sml_al})
                                      : ({1'b0, big_al} - {1'b0, sml_al});
      s2_mant_d = {sum, 20'd0};
      s2_exp_d  = $signed({4'd0, big.exp});
      if (sum == 28'd0)
        s2_sign_d = (big.sign == sml.sign) ? big.sign : (s1_rm_q == RM_RD);
      else
        s2_sign_d = big.sign;
    end
  end

  // Stage 3: normalize (and denormalize tiny results when enabled)
  always_comb begin
    s3_v_d    = s2_v_q;
    s3_rm_d   = s2_rm_q;
    s3_sp_d   = s2_sp_q;
    s3_sign_d = s2_sign_q;
    lz   = lzc48(s2_mant_q);
    norm = s2_mant_q << lz;
    e_n  = s2_exp_q + 12'sd1 - $signed({6'd0, lz});
    xs   = 1'b0;
    if (s2_mant_q == 48'd0) e_n = '0;
`ifdef FPU_DENORM_EN
    dsh     = 12'sd1 - e_n;
    dsh_amt = (dsh > 12'sd48) ? 7'd48 : dsh[6:0];
    ext     = {norm, 48'd0} >> dsh_amt;
    if ((s2_mant_q != 48'd0) && (e_n < 12'sd1)) begin
      norm = ext[95:48];
      xs   = |ext[47:0];
      e_n  = '0;
    end
`endif
    s3_exp_d = e_n;
    s3_sig_d = norm[47:24];
    s3_g_d   = norm[23];
    s3_r_d   = norm[22];
    s3_s_d   = (|norm[21:0]) | xs;
  end

  fpu_round u_round (
    .sign      (s3_sign_q),
    .exp       (s3_exp_q),
    .sig       (s3_sig_q),
    .g         (s3_g_q),
    .r         (s3_r_q),
    .s         (s3_s_q),
    .rmode     (s3_rm_q),
    .res       (rnd_res),
    .ine       (rnd_ine),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

  // Stage 4: select special or rounded result; flags derive from this op only
  always_comb begin
    out_d  = '0;
    snan_d = 1'b0;
    qnan_d = 1'b0;
    ine_d  = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inf_d  = 1'b0;
    zero_d = 1'b0;
    if (s3_v_q) begin
      if (s3_sp_q.hit) begin
        out_d  = s3_sp_q.res;
        snan_d = s3_sp_q.snan;
        qnan_d = s3_sp_q.qnan;
      end else begin
        out_d = rnd_res;
        ine_d = rnd_ine;
        ovf_d = rnd_ovf;
        unf_d = rnd_unf;
      end
      inf_d  = (out_d[30:0] == 31'h7F800000);
      zero_d = (out_d[30:0] == 31'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_v_q <= 1'b0;  in_op_q <= '0;  in_rm_q <= RM_RZ;  in_a_q <= '0;  in_b_q <= '0;
      s1_v_q <= 1'b0;  s1_mul_q <= 1'b0;  s1_rm_q <= RM_RZ;
      s1_a_q <= '0;    s1_b_q <= '0;    s1_sp_q <= '0;
      s2_v_q <= 1'b0;  s2_sign_q <= 1'b0;  s2_exp_q <= '0;  s2_mant_q <= '0;
      s2_rm_q <= RM_RZ;  s2_sp_q <= '0;
      s3_v_q <= 1'b0;  s3_sign_q <= 1'b0;  s3_exp_q <= '0;  s3_sig_q <= '0;
      s3_g_q <= 1'b0;  s3_r_q <= 1'b0;  s3_s_q <= 1'b0;  s3_rm_q <= RM_RZ;  s3_sp_q <= '0;
      out_q <= '0;  snan_q <= 1'b0;  qnan_q <= 1'b0;  inf_q <= 1'b0;  ine_q <= 1'b0;
      ovf_q <= 1'b0;  unf_q <= 1'b0;  zero_q <= 1'b0;
    end else begin
      in_v_q <= in_v_d;  in_op_q <= in_op_d;  in_rm_q <= in_rm_d;  in_a_q <= in_a_d;  in_b_q <= in_b_d;
      s1_v_q <= s1_v_d;  s1_mul_q <= s1_mul_d;  s1_rm_q <= s1_rm_d;
      s1_a_q <= s1_a_d;  s1_b_q <= s1_b_d;  s1_sp_q <= s1_sp_d;
      s2_v_q <= s2_v_d;  s2_sign_q <= s2_sign_d;  s2_exp_q <= s2_exp_d;  s2_mant_q <= s2_mant_d;
      s2_rm_q <= s2_rm_d;  s2_sp_q <= s2_sp_d;
      s3_v_q <= s3_v_d;  s3_sign_q <= s3_sign_d;  s3_exp_q <= s3_exp_d;  s3_sig_q <= s3_sig_d;
      s3_g_q <= s3_g_d;  s3_r_q <= s3_r_d;  s3_s_q <= s3_s_d;  s3_rm_q <= s3_rm_d;  s3_sp_q <= s3_sp_d;
      out_q <= out_d;  snan_q <= snan_d;  qnan_q <= qnan_d;  inf_q <= inf_d;  ine_q <= ine_d;
      ovf_q <= ovf_d;  unf_q <= unf_d;  zero_q <= zero_d;
    end
  end

  assign out         = out_q;
  assign snan        = snan_q;
  assign qnan        = qnan_q;
  assign inf         = inf_q;
  assign ine         = ine_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign zero        = zero_q;
  assign div_by_zero = 1'b0;

endmodule

// File: tb/tb_fpu_core.sv
// Scoreboard bench for fpu_core: directed vectors with hand-computed results and flags.
module tb_fpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rmode = 2'd0;
  logic [2:0]  fpu_op = 3'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic [31:0] out;
  logic        snan, qnan, inf, ine, overflow, underflow, div_by_zero, zero;
  logic [7:0]  flags;

  fpu_core dut (
    .clk(clk), .rst_n(rst_n), .rmode(rmode), .fpu_op(fpu_op), .opa(opa), .opb(opb),
    .out(out), .snan(snan), .qnan(qnan), .inf(inf), .ine(ine), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero), .zero(zero)
  );

  always #5 clk = ~clk;

  // flag order: snan qnan inf ine overflow underflow div_by_zero zero
  assign flags = {snan, qnan, inf, ine, overflow, underflow, div_by_zero, zero};

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  fl;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [7:0]  fl;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic       issue = 1'b0;
  logic [4:0] vpipe = '0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vpipe <= '0;
    else        vpipe <= {vpipe[3:0], issue};
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (vpipe[4]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result out=%h flags=%b required=no result", out, flags);
      end else begin
        e = sb.pop_front();
        if (out !== e.res || flags !== e.fl) begin
          errors++;
          $display("FAIL vec%0d out=%h flags=%b required out=%h flags=%b",
                   e.id, out, flags, e.res, e.fl);
        end
      end
    end
  end

  task automatic send(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    fpu_op = v.op;
    rmode  = v.rm;
    opa    = v.a;
    opb    = v.b;
    issue  = 1'b1;
    e.id = id;
    e.res = v.res;
    e.fl = v.fl;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    issue = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cleared(input string nm);
    checks++;
    if (out !== 32'd0 || flags !== 8'd0) begin
      errors++;
      $display("FAIL %s out=%h flags=%b required out=00000000 flags=00000000", nm, out, flags);
    end
  endtask

  initial begin
    vecs.push_back('{3'd0, 2'd2, 32'h41C00000, 32'h40800000, 32'h41E00000, 8'h00});
    vecs.push_back('{3'd1, 2'd2, 32'h41C00000, 32'h40800000, 32'h41A00000, 8'h00});
    vecs.push_back('{3'd2, 2'd2, 32'h41C00000, 32'h40800000, 32'h42C00000, 8'h00});
    vecs.push_back('{3'd0, 2'd2, 32'h3F800000, 32'hBF800000, 32'h00000000, 8'h01});
    vecs.push_back('{3'd0, 2'd1, 32'h3F800000, 32'hBF800000, 32'h80000000, 8'h01});
    vecs.push_back('{3'd2, 2'd2, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 8'h38});
    vecs.push_back('{3'd2, 2'd0, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 8'h18});
    vecs.push_back('{3'd2, 2'd1, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 8'h18});
    vecs.push_back('{3'd2, 2'd3, 32'hFF7FFFFF, 32'h40000000, 32'hFF7FFFFF, 8'h18});
    vecs.push_back('{3'd0, 2'd2, 32'h3F800000, 32'h33800000, 32'h3F800000, 8'h10});
    vecs.push_back('{3'd0, 2'd3, 32'h3F800000, 32'h33800000, 32'h3F800001, 8'h10});
    vecs.push_back('{3'd0, 2'd2, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 8'hC0});
    vecs.push_back('{3'd2, 2'd2, 32'h00000000, 32'h7F800000, 32'h7FC00000, 8'h40});
    vecs.push_back('{3'd1, 2'd2, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 8'h40});
    vecs.push_back('{3'd0, 2'd2, 32'h7F800000, 32'h3F800000, 32'h7F800000, 8'h20});
    vecs.push_back('{3'd3, 2'd2, 32'h41C00000, 32'h40800000, 32'h7FC00000, 8'h40});
    vecs.push_back('{3'd2, 2'd2, 32'h80000000, 32'h40A00000, 32'h80000000, 8'h01});
    vecs.push_back('{3'd0, 2'd2, 32'h3F800000, 32'h3F800000, 32'h40000000, 8'h00});
    vecs.push_back('{3'd0, 2'd2, 32'h3F7FFFFF, 32'h33800000, 32'h3F800000, 8'h00});
    vecs.push_back('{3'd0, 2'd3, 32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 8'h10});
`ifdef FPU_DENORM_EN
    vecs.push_back('{3'd2, 2'd2, 32'h00800000, 32'h3F000000, 32'h00400000, 8'h00});
`else
    vecs.push_back('{3'd2, 2'd2, 32'h00800000, 32'h3F000000, 32'h00000000, 8'h15});
`endif

    repeat (3) @(negedge clk);
    check_cleared("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) send(vecs[i], i);
    idle(8);

    // Two ops in flight, then reset: outputs clear at once and the ops are discarded.
    send(vecs[0], 100);
    send(vecs[5], 101);
    @(negedge clk);
    issue = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("reset_midflight");
    sb.delete();
    @(negedge clk);
    check_cleared("reset_hold");
    rst_n = 1'b1;

    send('{3'd2, 2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 8'h00}, 200);
    idle(8);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_core.md
# fpu_core

Single-precision IEEE-754 arithmetic unit performing add, subtract and multiply on 32-bit operands with four selectable rounding modes. It is fully pipelined: one new operation is accepted every cycle and each result appears a fixed four cycles later, together with its exception flags. It sits in the datapath as a free-running slave with no handshake, driven directly by the issuing logic.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rmode  in  2  rounding mode:
  - 0: toward zero
  - 1: toward −inf
  - 2: nearest-even
  - 3: toward +inf
- fpu_op  in  3  operation: 0 add, 1 sub, 2 mul; 3–7 unsupported
- opa  in  32  operand A, IEEE binary32
- opb  in  32  operand B, IEEE binary32
- out  out  32  result
- snan  out  1  either operand is a signaling NaN
- qnan  out  1  result is NaN
- inf  out  1  result is ±infinity
- ine  out  1  result is inexact
- overflow  out  1  rounded exponent exceeded 254
- underflow  out  1  result is tiny and inexact, or was flushed to zero
- div_by_zero  out  1  tied 0; no divide in this block
- zero  out  1  result is ±0

## Operation
- Sub is add with the sign of opb inverted.
- Add path:
  - Align the smaller operand by right shift, with guard/round/sticky bits retained.
  - Add or subtract the 24-bit significands.
  - Normalize with a leading-zero count.
- Mul path:
  - 24×24 significand product.
  - Exponent is ea+eb−127.
  - Normalize the 48-bit product to 24 bits plus GRS.
- Both paths feed a shared round/pack stage.
- Rounding is per rmode, with increments carried into the exponent.
- NaN handling:
  - Any NaN input produces canonical qNaN 0x7FC00000.
  - inf−inf (effective) and 0×inf also produce 0x7FC00000; qnan=1, snan=0.
- Infinity inputs propagate with the correct sign. Finite-by-infinity multiply gives ±inf.
- Overflow result by mode:
  - Nearest-even: ±inf.
  - Toward zero: ±0x7F7FFFFF.
  - Toward −inf: +max or −inf.
  - Toward +inf: +inf or −max.
  - overflow=1 and ine=1; inf=1 only when an inf is produced.
- Exact cancellation x+(−x) gives +0, or −0 in mode 1. Sign of a zero product is the XOR of the operand signs.
- Unsupported fpu_op: out=0x7FC00000, qnan=1, all other flags 0.
- Flags are pure functions of the operation they accompany. They are not sticky.

## Timing
- Operands, op and rmode are sampled on rising edge N. out and all flags are valid after edge N+4.
- Four register stages:
  - Stage 1: unpack/special-case detect.
  - Stage 2: align or multiply.
  - Stage 3: normalize.
  - Stage 4: round/pack.
- Throughput is one operation per cycle. Back-to-back operations with differing rmode/op do not interact.
- Reset behaviour:
  - While rst_n=0, all pipeline registers clear and out=0, all flags 0, zero=0.
  - Reset asserted mid-flight discards in-flight operations.
  - After release, the first valid result appears 4 edges after the first sampled input.

## Configuration
- FPU_DENORM_EN defined:
  - Subnormal inputs are handled exactly, with hidden bit 0 and exponent 1.
  - Tiny results are denormalized before rounding.
  - underflow is set when the result is tiny and inexact.
- Not defined (flush-to-zero):
  - Subnormal inputs are treated as ±0.
  - Results with biased exponent <1 after rounding become ±0 with underflow=1, ine=1, zero=1.

## Structure
- Package fpu_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_MUL.
  - rmode encodings: RM_RZ, RM_RD, RM_RNE, RM_RU.
  - constant QNAN=32'h7FC00000, MAX_FIN=32'h7F7FFFFF, BIAS=127.
  - Unpacked-operand struct: sign, exp[7:0], man[23:0], is_zero, is_inf, is_nan, is_snan.
- One sub-module, fpu_round: normalized significand plus GRS, exponent, sign and rmode in; packed result plus ine/overflow/underflow out. Instantiated once in stage 4.

## Test plan
- rmode=2, op=0, opa=0x41C00000 (24), opb=0x40800000 (4) → after 4 cycles out=0x41E00000 (28), all flags 0.
- Same operands, op=1 → 0x41A00000 (20). op=2 → 0x42C00000 (96). Issued on consecutive cycles, results appear on consecutive cycles.
- op=0, 0x3F800000 + 0xBF800000 → 0x00000000 with zero=1; rmode=1 → 0x80000000.
- op=2, 0x7F7FFFFF × 0x40000000, rmode=2 → 0x7F800000, overflow=inf=ine=1; rmode=0 → 0x7F7FFFFF, inf=0.
- op=0, 0x3F800000 + 0x33800000 (2^−24): rmode=2 → 0x3F800000, ine=1; rmode=3 → 0x3F800001.
- op=0, 0x7F800001 + 0x3F800000 → 0x7FC00000, snan=qnan=1. Assert rst_n low mid-pipeline → out and flags 0 immediately.
